rc4_decrypt_message: RTL
========================

Name: rc4_decrypt_message

Overview:
RC4 PRGA stage of the brute-force key search. It runs after the key-scheduling stage has permuted the S memory, and sits directly upstream of the message verifier. On start it generates MSG_LEN keystream bytes from S, XORs each with the encrypted-message ROM, and writes the results into the decrypted-message RAM that the verifier then scans. It uses the same start/finish handshake as the other brute-force stages.

Parameters:
MSG_LEN, 32, number of message bytes to decrypt (must be a power of 2, at most 2^MSG_ADDR_W)
MSG_ADDR_W, 5, width of the message ROM and RAM addresses

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  level; sampled only in IDLE
finish  out  1  high when IDLE (ready / done), low while busy
s_address  out  8  S RAM address
s_data  out  8  S RAM write data
s_wren  out  1  S RAM write enable
s_q  in  8  S RAM read data, valid 2 cycles after address is presented
rom_address  out  MSG_ADDR_W  encrypted ROM address
rom_q  in  8  encrypted ROM data, same latency as s_q
dec_address  out  MSG_ADDR_W  decrypted RAM address
dec_data  out  8  decrypted RAM write data
dec_wren  out  1  decrypted RAM write enable

Behaviour:
- Fixed: one clock; reset is asynchronous and active-low (reset_n).
- Reset (reset_n low, at any time including mid-run):
  - state goes to IDLE.
  - i, j, k, si, sj and f are cleared.
  - All outputs are 0 except finish, which is 1.
- Registers:
  - i is 8 bits, j is 8 bits, k is MSG_ADDR_W bits.
  - si, sj and f are 8 bits.
  - All arithmetic is modulo 256 (8-bit wrap). k wraps at MSG_LEN.
- States and transitions, one cycle each unless noted:
  - IDLE: finish=1. If start is high, go to INIT; otherwise stay.
  - INIT: set i=1, j=0, k=0.
  - RD_SI: s_address=i.
  - WT_SI: s_address=i held.
  - CP_SI: si <= s_q; j <= j + s_q.
  - RD_SJ: s_address=j (the updated j).
  - WT_SJ: s_address=j held.
  - CP_SJ: sj <= s_q.
  - WR_SI: s_address=i, s_data=sj, s_wren=1.
  - WR_SJ: s_address=j, s_data=si, s_wren=1.
  - RD_F: s_address=si+sj.
  - WT_F: s_address=si+sj held.
  - CP_F: f <= s_q.
  - WR_DEC: dec_address=k, dec_data = f ^ rom_q, dec_wren=1. If k == MSG_LEN-1, go to IDLE. Otherwise k++, i++, and go to RD_SI.
- rom_address equals k in every non-IDLE state. k is stable for 11 cycles before each WR_DEC read, so rom_q is valid there.
- When i == j, both writes hit the same address. The second write (si) wins, which is correct because si == sj in that case.
- Latency and write counts:
  - Each byte takes 12 cycles.
  - Start is sampled at edge 0; finish returns high at edge 12*MSG_LEN+1 (385 with defaults).
  - s_wren pulses exactly 2*MSG_LEN times; dec_wren pulses exactly MSG_LEN times, at ascending addresses 0..MSG_LEN-1.
- start high while busy is ignored. If start is still high when the block re-enters IDLE, a new run begins on the next edge.
- S is modified in place. Rerunning KSA before another decrypt is the controller's job.
- When not in a write state, s_wren, dec_wren, s_data and dec_data are all 0.

Test Plan:
- Identity S (S[x]=x), ROM all 0x00, pulse start for 1 cycle -> dec[0..2] = 0x02, 0x05, 0x07. Afterwards S[2]=0x03, S[3]=0x05, S[5]=0x02.
- Identity S, ROM all 0xFF -> dec[0..2] = 0xFD, 0xFA, 0xF8. finish is low for exactly 385 cycles. 32 dec_wren pulses at addresses 0..31 ascending. 64 s_wren pulses.
- Random S permutation (seeded) and random ROM -> all 32 dec bytes and the final 256-byte S match a software RC4 PRGA model.
- Assert reset_n low in CP_SJ of byte 10 -> outputs go to 0 and finish to 1 without waiting for a clock edge. No write strobes after that. A new start runs a full 385-cycle pass.
- Toggle start during the run, then hold start high through completion -> mid-run pulses have no effect. A second run starts the cycle after finish rises (finish high for 1 cycle only).
- S chosen so that j == i at byte 0 (S[1]=0, then j=0 only if... use S[1]=0xFF... use model-chosen S with i==j) -> the same-address double write leaves S unchanged at that index, and dec matches the model.

Source files
------------

// File: rtl/rc4_decrypt_message_if.sv
`timescale 1ns/1ps
// Bus bundle for the RC4 PRGA stage: start/finish handshake, S RAM port,
// encrypted-message ROM port and decrypted-message RAM port.
interface rc4_decrypt_message_if #(
    parameter int MSG_ADDR_W = 5
);
    logic                  start;
    logic                  finish;
    logic [7:0]            s_address;
    logic [7:0]            s_data;
    logic                  s_wren;
    logic [7:0]            s_q;
    logic [MSG_ADDR_W-1:0] rom_address;
    logic [7:0]            rom_q;
    logic [MSG_ADDR_W-1:0] dec_address;
    logic [7:0]            dec_data;
    logic                  dec_wren;

    // Controller / memory side: issues start, returns memory read data.
    modport master (
        output start,
        output s_q,
        output rom_q,
        input  finish,
        input  s_address,
        input  s_data,
        input  s_wren,
        input  rom_address,
        input  dec_address,
        input  dec_data,
        input  dec_wren
    );

    // Decrypt stage side.
    modport slave (
        input  start,
        input  s_q,
        input  rom_q,
        output finish,
        output s_address,
        output s_data,
        output s_wren,
        output rom_address,
        output dec_address,
        output dec_data,
        output dec_wren
    );
endinterface

// File: rtl/rc4_decrypt_message.sv
`timescale 1ns/1ps
// RC4 PRGA stage: generates MSG_LEN keystream bytes from the permuted S RAM,
// XORs them with the encrypted ROM and writes the result to the decrypted RAM.
// S and ROM reads have two cycles of latency, hence the RD/WT/CP triplets.
module rc4_decrypt_message #(
    parameter int MSG_LEN    = 32,
    parameter int MSG_ADDR_W = 5
) (
    input logic                  clk,
    input logic                  reset_n,
    rc4_decrypt_message_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_SI,
        ST_WT_SI,
        ST_CP_SI,
        ST_RD_SJ,
        ST_WT_SJ,
        ST_CP_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_WT_F,
        ST_CP_F,
        ST_WR_DEC
    } state_t;

    localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LEN - 1);

    state_t                state_q, state_d;
    logic [7:0]            i_q, i_d;
    logic [7:0]            j_q, j_d;
    logic [MSG_ADDR_W-1:0] k_q, k_d;
    logic [7:0]            si_q, si_d;
    logic [7:0]            sj_q, sj_d;
    logic [7:0]            f_q, f_d;

    // State and datapath registers; reset returns the block to IDLE at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
        end
    end

    // Next-state and datapath update: one PRGA byte every 12 cycles.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_INIT;
            end
            ST_INIT: begin
                i_d     = 8'd1;
                j_d     = '0;
                k_d     = '0;
                state_d = ST_RD_SI;
            end
            ST_RD_SI: state_d = ST_WT_SI;
            ST_WT_SI: state_d = ST_CP_SI;
            ST_CP_SI: begin
                si_d    = bus.s_q;
                j_d     = j_q + bus.s_q;
                state_d = ST_RD_SJ;
            end
            ST_RD_SJ: state_d = ST_WT_SJ;
            ST_WT_SJ: state_d = ST_CP_SJ;
            ST_CP_SJ: begin
                sj_d    = bus.s_q;
                state_d = ST_WR_SI;
            end
            ST_WR_SI: state_d = ST_WR_SJ;
            ST_WR_SJ: state_d = ST_RD_F;
            ST_RD_F:  state_d = ST_WT_F;
            ST_WT_F:  state_d = ST_CP_F;
            ST_CP_F: begin
                f_d     = bus.s_q;
                state_d = ST_WR_DEC;
            end
            ST_WR_DEC: begin
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = k_q + 1'b1;
                    i_d     = i_q + 8'd1;
                    state_d = ST_RD_SI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-port outputs decoded from the current state; zero outside use.
    always_comb begin
        bus.finish      = 1'b0;
        bus.s_address   = '0;
        bus.s_data      = '0;
        bus.s_wren      = 1'b0;
        bus.rom_address = '0;
        bus.dec_address = '0;
        bus.dec_data    = '0;
        bus.dec_wren    = 1'b0;
        if (state_q != ST_IDLE) bus.rom_address = k_q;
        unique case (state_q)
            ST_IDLE: bus.finish = 1'b1;
            ST_RD_SI, ST_WT_SI: bus.s_address = i_q;
            ST_RD_SJ, ST_WT_SJ: bus.s_address = j_q;
            ST_WR_SI: begin
                bus.s_address = i_q;
                bus.s_data    = sj_q;
                bus.s_wren    = 1'b1;
            end
            ST_WR_SJ: begin
                // When i == j this overwrites the previous write with the
                // same value (si == sj), leaving S[i] unchanged.
                bus.s_address = j_q;
                bus.s_data    = si_q;
                bus.s_wren    = 1'b1;
            end
            ST_RD_F, ST_WT_F: bus.s_address = si_q + sj_q;
            ST_WR_DEC: begin
                bus.dec_address = k_q;
                bus.dec_data    = f_q ^ bus.rom_q;
                bus.dec_wren    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
